// File: rtl/riscv_instr_aligner_pkg.sv
// Shared types for the fetch-to-decode aligner: halfword queue entry and
// the RISC-V instruction-length predicate.
package riscv_instr_aligner_pkg;

  localparam int HalfwordWidth = 16;

  typedef struct packed {
    logic                     err;
    logic [HalfwordWidth-1:0] hw;
  } hw_entry_t;

  // A halfword starts a 32-bit instruction only when its two low bits are 2'b11.
  function automatic logic is_compressed(input logic [HalfwordWidth-1:0] hw);
    return (hw & 16'h0003) != 16'h0003;
  endfunction

endpackage

// File: rtl/riscv_halfword_fifo.sv
// Circular halfword queue with 0/1/2-entry push and pop per cycle and a
// two-entry peek at the head.
module riscv_halfword_fifo
  import riscv_instr_aligner_pkg::*;
#(
  parameter int QDepth = 6,
  localparam int PtrW = $clog2(QDepth),
  localparam int CntW = $clog2(QDepth + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic [1:0]      push_cnt_i,
  input  hw_entry_t       push0_i,
  input  hw_entry_t       push1_i,
  input  logic [1:0]      pop_cnt_i,
  output hw_entry_t       head0_o,
  output hw_entry_t       head1_o,
  output logic [CntW-1:0] count_o
);

  logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  hw_entry_t       mem_q [QDepth];
  hw_entry_t       mem_d [QDepth];

  function automatic logic [PtrW-1:0] ptr_add(input logic [PtrW-1:0] p, input logic [1:0] n);
    logic [PtrW:0] s;
    s = {1'b0, p} + (PtrW+1)'(n);
    if (s >= (PtrW+1)'(QDepth)) s = s - (PtrW+1)'(QDepth);
    return s[PtrW-1:0];
  endfunction

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_cnt_i != 2'd0) mem_d[wr_q] = push0_i;
      if (push_cnt_i == 2'd2) mem_d[ptr_add(wr_q, 2'd1)] = push1_i;
      wr_d  = ptr_add(wr_q, push_cnt_i);
      rd_d  = ptr_add(rd_q, pop_cnt_i);
      cnt_d = cnt_q + CntW'(push_cnt_i) - CntW'(pop_cnt_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head0_o = mem_q[rd_q];
  assign head1_o = mem_q[ptr_add(rd_q, 2'd1)];
  assign count_o = cnt_q;

  push_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (push_cnt_i != 2'd0 && !flush_i) |-> (cnt_q <= CntW'(QDepth - 2)));

  pop_within_count: assert property (@(posedge clk) disable iff (!rst_n)
    (pop_cnt_i != 2'd0 && !flush_i) |-> (CntW'(pop_cnt_i) <= cnt_q));

endmodule

// File: rtl/riscv_instr_aligner.sv
// Fetch-to-decode aligner: splits fetch words into halfwords and presents one
// whole 16- or 32-bit instruction per handshake with its PC.
module riscv_instr_aligner
  import riscv_instr_aligner_pkg::*;
#(
  parameter int                   DataWidth = 32,
  parameter int                   QDepth    = 6,
  parameter logic [DataWidth-1:0] ResetPc   = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic [DataWidth-1:0] flush_pc_i,
  input  logic                 fetch_valid_i,
  output logic                 fetch_ready_o,
  input  logic [31:0]          fetch_data_i,
  input  logic                 fetch_err_i,
  output logic                 instr_valid_o,
  input  logic                 instr_ready_i,
  output logic [31:0]          instr_o,
  output logic [DataWidth-1:0] pc_o,
  output logic                 compressed_o,
  output logic                 instr_err_o
);

  localparam int CntW = $clog2(QDepth + 1);

  hw_entry_t            head0, head1, push0, push1;
  logic [CntW-1:0]      count;
  logic [DataWidth-1:0] pc_q, pc_d;
  logic                 skip_q, skip_d, ready_en_q;
  logic                 short_instr, avail, push, pop, err_raw;
  logic [1:0]           push_cnt, pop_cnt;
  logic [31:0]          instr_raw;

  // A faulting head is always popped as one halfword so an erroneous fetch
  // can never wait forever for a second halfword.
  always_comb begin
    short_instr   = head0.err | is_compressed(head0.hw);
    avail         = short_instr ? (count >= CntW'(1)) : (count >= CntW'(2));
    instr_valid_o = avail & ~flush_i;
    instr_raw     = short_instr ? {16'h0000, head0.hw} : {head1.hw, head0.hw};
    err_raw       = short_instr ? head0.err : (head0.err | head1.err);
    instr_o       = instr_valid_o ? instr_raw : 32'h0;
    instr_err_o   = instr_valid_o & err_raw;
    compressed_o  = instr_valid_o & ~(instr_o[0] & instr_o[1]);
    pop           = instr_valid_o & instr_ready_i;
    pop_cnt       = pop ? (short_instr ? 2'd1 : 2'd2) : 2'd0;
  end

  assign fetch_ready_o = ready_en_q & (count <= CntW'(QDepth - 2));

  always_comb begin
    push     = fetch_valid_i & fetch_ready_o & ~flush_i;
    push_cnt = push ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
    push0    = skip_q ? {fetch_err_i, fetch_data_i[31:16]} : {fetch_err_i, fetch_data_i[15:0]};
    push1    = {fetch_err_i, fetch_data_i[31:16]};
    pc_d     = pc_q;
    skip_d   = skip_q;
    if (flush_i) begin
      pc_d   = flush_pc_i & ~DataWidth'(1);
      skip_d = flush_pc_i[1];
    end else begin
      if (pop)  pc_d   = pc_q + (short_instr ? DataWidth'(2) : DataWidth'(4));
      if (push) skip_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= ResetPc;
      skip_q     <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      skip_q     <= skip_d;
      ready_en_q <= 1'b1;
    end
  end

  assign pc_o = pc_q;

  riscv_halfword_fifo #(.QDepth(QDepth)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush_i),
    .push_cnt_i (push_cnt),
    .push0_i    (push0),
    .push1_i    (push1),
    .pop_cnt_i  (pop_cnt),
    .head0_o    (head0),
    .head1_o    (head1),
    .count_o    (count)
  );

  output_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (instr_valid_o && !instr_ready_i && !flush_i) ##1 !flush_i
      |-> (instr_valid_o && $stable(instr_o) && $stable(pc_o)));

endmodule

// File: tb/tb_riscv_instr_aligner.sv
// Self-checking bench for riscv_instr_aligner: directed vectors, multi-cycle
// corner sequences and a randomized run against a halfword-queue model.
module tb_riscv_instr_aligner;

  localparam int QDepth = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_data_i;
  logic        fetch_err_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        compressed_o;
  logic        instr_err_o;

  int testsRun = 0;
  int testsFailed = 0;

  riscv_instr_aligner #(.DataWidth(32), .QDepth(QDepth), .ResetPc(32'h0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush_i),
    .flush_pc_i    (flush_pc_i),
    .fetch_valid_i (fetch_valid_i),
    .fetch_ready_o (fetch_ready_o),
    .fetch_data_i  (fetch_data_i),
    .fetch_err_i   (fetch_err_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .compressed_o  (compressed_o),
    .instr_err_o   (instr_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] flushPc;
    logic [31:0] word;
    logic        err;
    logic        expValid;
    logic [31:0] expInstr;
    logic [31:0] expPc;
    logic        expC;
    logic        expErr;
    logic [31:0] pcAfter;
  } vec_t;

  // Drives one cycle of inputs at the falling edge; outputs are then sampled
  // 1 time unit later, well away from the rising edge.
  task automatic applyStimulus(input logic fv, input logic [31:0] d, input logic e,
                               input logic rdy, input logic fl, input logic [31:0] fpc);
    @(negedge clk);
    fetch_valid_i = fv;
    fetch_data_i  = d;
    fetch_err_i   = e;
    instr_ready_i = rdy;
    flush_i       = fl;
    flush_pc_i    = fpc;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic expValid, input logic [31:0] expInstr,
                             input logic [31:0] expPc, input logic expC, input logic expErr,
                             input logic expReady);
    logic ok;
    testsRun++;
    ok = (instr_valid_o === expValid) && (pc_o === expPc) && (fetch_ready_o === expReady);
    if (expValid)
      ok = ok && (instr_o === expInstr) && (compressed_o === expC) && (instr_err_o === expErr);
    if (!ok) begin
      testsFailed++;
      $display("[TB] FAIL %s: got valid=%0b instr=%h pc=%h c=%0b err=%0b rdy=%0b, want valid=%0b instr=%h pc=%h c=%0b err=%0b rdy=%0b",
               name, instr_valid_o, instr_o, pc_o, compressed_o, instr_err_o, fetch_ready_o,
               expValid, expInstr, expPc, expC, expErr, expReady);
    end
  endtask

  task automatic checkValue(input string name, input logic [127:0] act, input logic [127:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  vec_t        vecs [7];
  logic [16:0] q [$];
  logic [31:0] mpc;
  logic        mskip;
  logic        holdV, holdE;
  logic [31:0] holdD;
  logic        fv, e, rdy, fl, accepted;
  logic        expValid, expC, expErr, expReady;
  logic [31:0] d, fpc, expInstr;
  logic [16:0] head;
  int          len;

  initial begin
    vecs[0] = '{32'h0000_0000, 32'h00A0_0093, 1'b0, 1'b1, 32'h00A0_0093, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0004};
    vecs[1] = '{32'h0000_0000, 32'h4505_4501, 1'b0, 1'b1, 32'h0000_4501, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0002};
    vecs[2] = '{32'h0000_0102, 32'h0001_FFFF, 1'b0, 1'b1, 32'h0000_0001, 32'h0000_0102, 1'b1, 1'b0, 32'h0000_0104};
    vecs[3] = '{32'h0000_0200, 32'h1234_FFFF, 1'b1, 1'b1, 32'h0000_FFFF, 32'h0000_0200, 1'b0, 1'b1, 32'h0000_0202};
    vecs[4] = '{32'hFFFF_FFFE, 32'h4501_0000, 1'b0, 1'b1, 32'h0000_4501, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0000_0000};
    vecs[5] = '{32'h0000_0011, 32'h0000_0013, 1'b0, 1'b1, 32'h0000_0013, 32'h0000_0010, 1'b0, 1'b0, 32'h0000_0014};
    vecs[6] = '{32'h0000_0022, 32'h0013_4501, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0022, 1'b0, 1'b0, 32'h0000_0022};

    rst_n = 1'b0;
    flush_i = 1'b0; flush_pc_i = '0; fetch_valid_i = 1'b0; fetch_data_i = '0;
    fetch_err_i = 1'b0; instr_ready_i = 1'b0;
    #3;
    checkValue("resetState", {instr_valid_o, instr_o, pc_o, compressed_o, instr_err_o, fetch_ready_o},
               {1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("readyAfterReset", 0, 0, 32'h0, 0, 0, 1);

    // Directed vectors: redirect, push one word, consume the first instruction.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 0, 0, 0, 1, vecs[i].flushPc);
      checkValue($sformatf("vec%0d_flushCycle", i), instr_valid_o, 0);
      applyStimulus(1, vecs[i].word, vecs[i].err, 0, 0, 0);
      checkValue($sformatf("vec%0d_afterFlush", i), instr_valid_o, 0);
      applyStimulus(0, 0, 0, 1, 0, 0);
      checkOutput($sformatf("vec%0d_first", i), vecs[i].expValid, vecs[i].expInstr, vecs[i].expPc,
                  vecs[i].expC, vecs[i].expErr, 1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkValue($sformatf("vec%0d_pcAfter", i), pc_o, vecs[i].pcAfter);
    end

    // Instruction straddling two fetch words.
    applyStimulus(0, 0, 0, 0, 1, 32'h0);
    applyStimulus(1, 32'h0093_4501, 0, 0, 0, 0);
    checkOutput("straddle_empty", 0, 0, 32'h0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("straddle_cli", 1, 32'h0000_4501, 32'h0, 1, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("straddle_waitHalf", 0, 0, 32'h2, 0, 0, 1);
    applyStimulus(1, 32'h0000_00A0, 0, 1, 0, 0);
    checkOutput("straddle_pushSecond", 0, 0, 32'h2, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("straddle_addi", 1, 32'h00A0_0093, 32'h2, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("straddle_tail", 1, 32'h0000_0000, 32'h6, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("straddle_done", 0, 0, 32'h8, 0, 0, 1);

    // Backpressure fills the queue, then an in-order drain.
    applyStimulus(0, 0, 0, 0, 1, 32'h0);
    applyStimulus(1, 32'h4505_4501, 0, 0, 0, 0);
    checkOutput("bp_push0", 0, 0, 32'h0, 0, 0, 1);
    applyStimulus(1, 32'h00A0_0093, 0, 0, 0, 0);
    checkOutput("bp_push1", 1, 32'h0000_4501, 32'h0, 1, 0, 1);
    applyStimulus(1, 32'h4509_450D, 0, 0, 0, 0);
    checkOutput("bp_push2", 1, 32'h0000_4501, 32'h0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("bp_full", 1, 32'h0000_4501, 32'h0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("bp_drain0", 1, 32'h0000_4501, 32'h0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("bp_drain1", 1, 32'h0000_4505, 32'h2, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("bp_drain2", 1, 32'h00A0_0093, 32'h4, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("bp_drain3", 1, 32'h0000_450D, 32'h8, 1, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("bp_drain4", 1, 32'h0000_4509, 32'hA, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("bp_empty", 0, 0, 32'hC, 0, 0, 1);

    // Faulting fetch drains as halfwords, then reset lands mid-drain.
    applyStimulus(0, 0, 0, 0, 1, 32'h300);
    applyStimulus(1, 32'h4501_FFFF, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("err_first", 1, 32'h0000_FFFF, 32'h300, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("err_second", 1, 32'h0000_4501, 32'h302, 1, 1, 1);
    rst_n = 1'b0;
    #1;
    checkValue("midDrainReset", {instr_valid_o, instr_o, pc_o, compressed_o, instr_err_o, fetch_ready_o},
               {1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized run against the halfword-queue model.
    q.delete();
    mpc = 32'h0;
    mskip = 1'b0;
    holdV = 1'b0; holdD = '0; holdE = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      fl  = ($urandom_range(0, 39) == 0);
      fpc = $urandom;
      if (holdV) begin
        fv = 1'b1; d = holdD; e = holdE;
      end else begin
        fv = ($urandom_range(0, 2) != 0);
        d  = $urandom;
        e  = ($urandom_range(0, 9) == 0);
      end
      rdy = ($urandom_range(0, 3) != 0);
      applyStimulus(fv, d, e, rdy, fl, fpc);

      expReady = (q.size() <= QDepth - 2);
      expValid = 1'b0; expInstr = '0; expErr = 1'b0; len = 0;
      if (!fl && q.size() > 0) begin
        head = q[0];
        if (head[16] || head[1:0] != 2'b11) begin
          expValid = 1'b1; expInstr = {16'h0, head[15:0]}; expErr = head[16]; len = 1;
        end else if (q.size() >= 2) begin
          expValid = 1'b1; expInstr = {q[1][15:0], head[15:0]}; expErr = head[16] | q[1][16]; len = 2;
        end
      end
      expC = ~(expInstr[0] & expInstr[1]);
      checkOutput($sformatf("random%0d", i), expValid, expInstr, mpc, expC, expErr, expReady);

      accepted = fv && expReady && !fl;
      if (fl) begin
        q.delete();
        mpc   = fpc & ~32'h1;
        mskip = fpc[1];
      end else begin
        if (expValid && rdy) begin
          repeat (len) void'(q.pop_front());
          mpc = mpc + 32'(len * 2);
        end
        if (accepted) begin
          if (!mskip) q.push_back({e, d[15:0]});
          q.push_back({e, d[31:16]});
          mskip = 1'b0;
        end
      end
      holdV = fv && !accepted && !fl;
      holdD = d;
      holdE = e;
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/riscv_instr_aligner.md
Name: riscv_instr_aligner

Overview:
Fetch-to-decode aligner that sits directly upstream of the instruction decoder.
- Accepts 32-bit word-aligned fetch words and buffers them as halfwords.
- Presents one complete instruction per handshake (16-bit compressed or 32-bit), including instructions that straddle two fetch words.
- Tracks the PC of each emitted instruction and handles redirects (flush), including redirects to halfword-aligned targets.

Parameters:
DataWidth, 32, PC and fetch word width.
QDepth, 6, halfword queue depth (must be even, >= 4).
ResetPc, 32'h0000_0000, PC loaded at reset.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush_i  in  1  redirect: discard all buffered state
flush_pc_i  in  DataWidth  redirect target (bit 0 ignored)
fetch_valid_i  in  1  fetch word valid
fetch_ready_o  out  1  aligner can accept a fetch word
fetch_data_i  in  32  word-aligned fetch data, little-endian halfwords
fetch_err_i  in  1  access fault for this fetch word
instr_valid_o  out  1  complete instruction available
instr_ready_i  in  1  decoder consumes instruction
instr_o  out  32  instruction; upper 16 bits zero when compressed
pc_o  out  DataWidth  PC of instr_o
compressed_o  out  1  ~(instr_o[0] & instr_o[1])
instr_err_o  out  1  fault on any halfword of instr_o

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - Queue empty, count=0, pc_q=ResetPc, skip_q=0.
  - instr_valid_o=0, instr_o=0, pc_o=ResetPc, compressed_o=0, instr_err_o=0.
  - fetch_ready_o=1 one cycle after reset deasserts. It is 0 while rst_n is low.
- Queue:
  - Each entry is {err, halfword[15:0]}. Read and write pointers wrap modulo QDepth.
- Push:
  - Occurs on fetch_valid_i & fetch_ready_o.
  - Normal case: writes low halfword then high halfword (+2 entries).
  - If skip_q=1: low halfword is discarded, only high halfword is written (+1), and skip_q clears.
- fetch_ready_o = (count <= QDepth-2). It depends on the registered count only and takes no credit for a same-cycle pop.
- Output is combinational from the queue head. Latency from fetch accept to instr_valid_o is 1 cycle.
  - Head halfword [1:0] != 2'b11: compressed instruction; needs count >= 1; pop 1; pc_q += 2.
  - Head halfword [1:0] == 2'b11: 32-bit instruction; needs count >= 2; instr_o = {head+1, head}; pop 2; pc_q += 4.
  - If a 32-bit head has count == 1, instr_valid_o=0 and the aligner waits for the next word.
  - instr_err_o = OR of err bits of the consumed halfwords.
  - If the head halfword has err=1, instr_valid_o is asserted with count >= 1 regardless of length. It is treated as a 16-bit pop so a faulting fetch cannot deadlock.
- Same-cycle push and pop are both performed. New count = count + pushed - popped. Count never exceeds QDepth.
- pc_q arithmetic is modulo 2^DataWidth; 32'hFFFF_FFFE + 2 wraps to 0.
- Valid/ready rules:
  - instr_valid_o must not drop and outputs must stay stable while instr_ready_i=0, except on flush.
  - Upstream must hold fetch_data_i stable while fetch_valid_i=1 and fetch_ready_o=0.
- Flush (highest priority):
  - Clears count and pointers; pc_q = {flush_pc_i[DataWidth-1:1], 1'b0}; skip_q = flush_pc_i[1].
  - A push or pop in the same cycle is dropped.
  - instr_valid_o=0 in the flush cycle and in the cycle after.
  - The first fetch word accepted after flush belongs to the word containing flush_pc_i.
- Asserting rst_n low mid-operation returns everything to the reset values immediately (asynchronous).
- Simulation assertions:
  - No push when count > QDepth-2.
  - No pop beyond count.
  - Outputs stable under backpressure.

Decomposition:
- defs_pkg gains HalfwordWidth=16 and the instruction-length predicate function is_compressed(halfword).
- Sub-module riscv_halfword_fifo: parameterised QDepth.
  - Dual-push (1 or 2 entries) and dual-pop (1 or 2 entries).
  - Outputs head and head+1 peek, plus count; has a flush input.
- riscv_instr_aligner holds pc_q, skip_q, length decode and the handshakes.

Test Plan:
- Reset, push 32'h00A00093 (addi) with pc=0 -> next cycle instr_o=32'h00A00093, compressed_o=0, pc_o=0; after ready, pc_o=4.
- Push 32'h4505_4501 (two c.li) -> 32'h4501 @pc 0, then 32'h4505 @pc 2; both compressed_o=1 and upper 16 bits zero.
- Straddle: push 32'h0093_4501, then 32'h0000_00A0 -> c.li @0, then 32'h00A00093 @2 with valid only after the second word; the remaining halfword 0000 is emitted @6 as compressed.
- flush_i with flush_pc_i=32'h102, then push 32'h0001_FFFF -> low halfword dropped; 32'h0001 emitted @32'h102, compressed_o=1.
- Hold instr_ready_i=0 while pushing 3 words at QDepth=6 -> fetch_ready_o=0 once count=5 or 6, no overflow, instr_o stable; release -> in-order drain with PCs +2/+4.
- Push a word with fetch_err_i=1 whose low halfword is 16'hFFFF -> instr_valid_o=1 with instr_err_o=1, 16-bit pop, no deadlock; assert rst_n low mid-drain -> instr_valid_o=0 and pc_o=ResetPc immediately.
